instr_fetch_queue: RTL

- Multi-issue instruction buffer between the fetch stage and the instruction decoder.
- Accepts up to FETCH_NUM sequential 32-bit instructions per cycle from fetch.
- Presents the oldest DECODE_NUM instructions in program order, with per-lane valid bits and PCs, as the decoder's instr array.
- Absorbs fetch/decode rate mismatch and is flushed on redirect.

---
 rtl/instr_fetch_queue.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Circular fetch-to-decode instruction buffer with multi-lane write and read.
// Optional occupancy statistics counters are enabled by defining FQ_STAT_EN.
module instr_fetch_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int FETCH_NUM  = 4,
  parameter int DECODE_NUM = 4,
  parameter int DEPTH      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic                                  wr_en,
  input  logic [$clog2(FETCH_NUM):0]            wr_cnt,
  input  logic [FETCH_NUM-1:0][31:0]            wr_instr,
  input  logic [DATA_WIDTH-1:0]                 wr_pc,
  output logic                                  wr_ready,
  output logic [DECODE_NUM-1:0][31:0]           rd_instr,
  output logic [DECODE_NUM-1:0][DATA_WIDTH-1:0] rd_pc,
  output logic [DECODE_NUM-1:0]                 rd_v,
  input  logic [$clog2(DECODE_NUM):0]           rd_cnt,
`ifdef FQ_STAT_EN
  output logic [31:0]                           stall_cnt,
  output logic [31:0]                           empty_cnt,
`endif
  output logic [$clog2(DEPTH):0]                count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [DEPTH-1:0][31:0]           mem_instr_q, mem_instr_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_pc_q, mem_pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_n, wr_acc_cnt, n_valid, rd_ext, eff_rd;
  logic          wr_acc;

  assign wr_ready = (count_q <= CW'(DEPTH - FETCH_NUM));
  assign count    = count_q;

  always_comb begin
    mem_instr_d = mem_instr_q;
    mem_pc_d    = mem_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;

    // Oversized wr_cnt is clamped so tail never runs past the lanes written.
    wr_n       = (CW'(wr_cnt) > CW'(FETCH_NUM)) ? CW'(FETCH_NUM) : CW'(wr_cnt);
    wr_acc     = wr_en && wr_ready && !flush;
    wr_acc_cnt = wr_acc ? wr_n : '0;
    n_valid    = (count_q < CW'(DECODE_NUM)) ? count_q : CW'(DECODE_NUM);
    rd_ext     = CW'(rd_cnt);
    eff_rd     = flush ? '0 : ((rd_ext < n_valid) ? rd_ext : n_valid);

    for (int k = 0; k < FETCH_NUM; k++) begin
      if (wr_acc && (CW'(k) < wr_n)) begin
        mem_instr_d[tail_q + PW'(k)] = wr_instr[k];
        mem_pc_d[tail_q + PW'(k)]    = wr_pc + DATA_WIDTH'(4 * k);
      end
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(eff_rd);
      tail_d  = tail_q + PW'(wr_acc_cnt);
      count_d = count_q + wr_acc_cnt - eff_rd;
    end
  end

  always_comb begin
    rd_v     = '0;
    rd_instr = '0;
    rd_pc    = '0;
    for (int k = 0; k < DECODE_NUM; k++) begin
      rd_v[k]     = CW'(k) < count_q;
      rd_instr[k] = rd_v[k] ? mem_instr_q[head_q + PW'(k)] : NOP;
      rd_pc[k]    = rd_v[k] ? mem_pc_q[head_q + PW'(k)] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= NOP;
        mem_pc_q[i]    <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_instr_q <= mem_instr_d;
      mem_pc_q    <= mem_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

`ifdef FQ_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, empty_cnt_q, empty_cnt_d;

  // Saturating event counters; only reset clears them.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    empty_cnt_d = empty_cnt_q;
    if (wr_en && !wr_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if ((count_q == '0) && !flush && (empty_cnt_q != 32'hFFFF_FFFF))
      empty_cnt_d = empty_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      empty_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      empty_cnt_q <= empty_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign empty_cnt = empty_cnt_q;
`endif

endmodule
